// File: rtl/led_seq_cpu.sv
// LED instruction sequencer: fetches {opcode, operand} from an external program store and drives a W-bit LED register.
// Optional WAIT opcode and its countdown state are built only when LED_SEQ_CPU_WAIT_EN is defined.
module led_seq_cpu #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         en,
   input  logic [W+3:0] data,
   output logic [W-1:0] addr,
   output logic [W-1:0] led,
   output logic         halted
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_NOT  = 4'd1,
      OP_LD   = 4'd2,
      OP_XOR  = 4'd3,
      OP_ROL  = 4'd4,
      OP_JMP  = 4'd5,
      OP_JNZ  = 4'd6,
      OP_WAIT = 4'd7,
      OP_HALT = 4'd8
   } opcode_t;

`ifdef LED_SEQ_CPU_WAIT_EN
   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_HALT = 2'd2
   } state_t;
`endif

   state_t         state;
   logic [3:0]     opc;
   logic [W-1:0]   operand;
   logic [W-1:0]   ip_inc;
`ifdef LED_SEQ_CPU_WAIT_EN
   logic [W-1:0]   cnt;
`endif

   always_comb begin
      opc     = data[W+3:W];
      operand = data[W-1:0];
      ip_inc  = addr + W'(1);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state  <= S_RUN;
         addr   <= '0;
         led    <= '0;
         halted <= 1'b0;
`ifdef LED_SEQ_CPU_WAIT_EN
         cnt    <= '0;
`endif
      end else if (en) begin
         case (state)
            S_RUN: begin
               case (opc)
                  OP_NOT: begin
                     led  <= ~led;
                     addr <= ip_inc;
                  end
                  OP_LD: begin
                     led  <= operand;
                     addr <= ip_inc;
                  end
                  OP_XOR: begin
                     led  <= led ^ operand;
                     addr <= ip_inc;
                  end
                  OP_ROL: begin
                     led  <= {led[W-2:0], led[W-1]};
                     addr <= ip_inc;
                  end
                  OP_JMP: addr <= operand;
                  OP_JNZ: addr <= (led != '0) ? operand : ip_inc;
`ifdef LED_SEQ_CPU_WAIT_EN
                  // The RUN cycle counts as the first of n+1, so the counter exits on 1.
                  OP_WAIT: begin
                     if (operand == '0) begin
                        addr <= ip_inc;
                     end else begin
                        cnt   <= operand;
                        state <= S_WAIT;
                     end
                  end
`endif
                  OP_HALT: begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end
                  default: addr <= ip_inc;
               endcase
            end
`ifdef LED_SEQ_CPU_WAIT_EN
            S_WAIT: begin
               cnt <= cnt - W'(1);
               if (cnt == W'(1)) begin
                  state <= S_RUN;
                  addr  <= ip_inc;
               end
            end
`endif
            S_HALT: halted <= 1'b1;
            default: state <= S_RUN;
         endcase
      end
   end

endmodule
